// File: rtl/flash_word_reader_pkg.sv
// ---------------------------------------------------------------------------
// flash_word_reader_pkg
// Shared definitions for the flash word reader: FSM state encoding, the number
// of bytes per assembled word and the flash byte-address width.
// ---------------------------------------------------------------------------
package flash_word_reader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int FLASH_AW   = 24;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BYTE = 3'd2,
    ST_PUSH      = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

endpackage

// File: rtl/flash_word_reader_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO, DEPTH must be a power of two.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i  write request and data; accepted when not full, or when
//                  full and a pop happens in the same cycle
//   pop_i          read request; accepted when not empty
//   data_o         head entry (zero while empty)
//   full_o/empty_o occupancy flags
// A push into an empty FIFO is not bypassed: empty_o drops the cycle after.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/flash_word_reader.sv
// ---------------------------------------------------------------------------
// flash_word_reader
// Reads a burst of bytes from an SPI flash controller, packs them
// little-endian into 32-bit words and queues the words in a small FIFO.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      burst request handshake (req_ready only in IDLE)
//   req_addr, req_words      first byte address, word count (0 means 256)
//   word_data/word_valid/
//   word_ready               FIFO head output stream
//   busy, done               burst in progress, one-cycle end-of-burst pulse
//   flash_valid, flash_addr  byte read request to the flash controller
//   flash_data, flash_ready  returned byte and its one-cycle strobe
//   dbg_state                current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the data travels with valid. req_*: ready depends on state only.
// word_*: valid is FIFO not-empty. flash_*: flash_valid holds, with a stable
// flash_addr, until the controller returns flash_ready for one cycle; the
// controller must not pulse flash_ready without an outstanding flash_valid.
// ---------------------------------------------------------------------------
module flash_word_reader
  import flash_word_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [FLASH_AW-1:0] req_addr,
  input  logic [7:0]          req_words,
  output logic [31:0]         word_data,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                busy,
  output logic                done,
  output logic                flash_valid,
  output logic [FLASH_AW-1:0] flash_addr,
  input  logic [7:0]          flash_data,
  input  logic                flash_ready,
  output state_e              dbg_state
);

  state_e              state_q;
  logic [FLASH_AW-1:0] addr_q;
  logic                flash_valid_q;
  logic [8:0]          remaining_q;
  logic [1:0]          byte_idx_q;
  logic [31:0]         word_q;
  logic                done_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                fifo_push;

  assign fifo_pop  = word_ready && !fifo_empty;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign fifo_push = (state_q == ST_PUSH) && (!fifo_full || fifo_pop);

  // flash_valid is registered: it rises on the edge that leaves ISSUE and
  // falls on the edge that captures the byte, so the ISSUE cycle that
  // follows every byte is the mandatory low gap between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      flash_valid_q <= 1'b0;
      remaining_q   <= '0;
      byte_idx_q    <= '0;
      word_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            remaining_q <= (req_words == 8'd0) ? 9'd256 : {1'b0, req_words};
            byte_idx_q  <= '0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          flash_valid_q <= 1'b1;
          state_q       <= ST_WAIT_BYTE;
        end
        ST_WAIT_BYTE: begin
          if (flash_ready) begin
            flash_valid_q                 <= 1'b0;
            word_q[{byte_idx_q, 3'b000} +: 8] <= flash_data;
            addr_q                        <= addr_q + 24'd1;
            byte_idx_q                    <= byte_idx_q + 2'd1;
            state_q <= (byte_idx_q == 2'(WORD_BYTES - 1)) ? ST_PUSH : ST_ISSUE;
          end
        end
        ST_PUSH: begin
          if (fifo_push) state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          remaining_q <= remaining_q - 9'd1;
          if (remaining_q == 9'd1) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .data_i  (word_q),
    .pop_i   (fifo_pop),
    .data_o  (word_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign word_valid  = !fifo_empty;
  assign flash_valid = flash_valid_q;
  assign flash_addr  = addr_q;
  assign dbg_state   = state_q;

endmodule
